// File: rtl/ctrl_types_pkg.sv
// Shared types for the cache controller sub-FSMs.
// Holds the DEL sub-state encoding, the result bundle and the default timeouts.
package ctrl_types_pkg;

    typedef enum logic [2:0] {
        DEL_ST_START        = 3'd0,
        DEL_ST_CHECK_EXISTS = 3'd1,
        ST_DEL_DELETE       = 3'd2,
        ST_DEL_DONE         = 3'd3,
        ST_DEL_ERROR        = 3'd4
    } del_substate_e;

    typedef struct packed {
        logic done;
        logic error;
    } sub_cmd_t;

    localparam int DEL_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/ctrl_wait_timer.sv
// Ack-wait counter shared by the controller sub-FSMs.
// Expires when the count reaches MAX_CYCLES; MAX_CYCLES=0 never expires.
module ctrl_wait_timer #(
    parameter int MAX_CYCLES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = (MAX_CYCLES > 0) ? $clog2(MAX_CYCLES + 1) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_expired;

    // Terminal count reached; a zero limit disables expiry entirely.
    always_comb begin
        w_expired = (MAX_CYCLES != 0) && (r_cnt == CW'(MAX_CYCLES));
    end

    // Clear on entry to a wait state, count ack-less cycles, hold at expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && !w_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired_o = w_expired;

endmodule

// File: rtl/ctrl_del_fsm.sv
// Delete sub-FSM: look up the key, clear the matching valid bit,
// report a single done or error pulse back to the top controller.
module ctrl_del_fsm
    import ctrl_types_pkg::*;
#(
    parameter int NUM_ENTRIES    = 16,
    parameter int KEY_WIDTH      = 64,
    parameter int IDX_WIDTH      = $clog2(NUM_ENTRIES),
    parameter int TIMEOUT_CYCLES = DEL_TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [KEY_WIDTH-1:0] key_i,
    output logic                 lookup_req_o,
    output logic [KEY_WIDTH-1:0] lookup_key_o,
    input  logic                 lookup_ack_i,
    input  logic                 lookup_hit_i,
    input  logic [IDX_WIDTH-1:0] lookup_idx_i,
    output logic                 clr_req_o,
    output logic [IDX_WIDTH-1:0] clr_idx_o,
    input  logic                 clr_ack_i,
    output sub_cmd_t             cmd_o,
    output logic                 busy_o,
    output del_substate_e        state_o
);

    del_substate_e        r_state;
    del_substate_e        w_next;
    logic [KEY_WIDTH-1:0] r_key;
    logic [IDX_WIDTH-1:0] r_idx;
    logic                 w_idx_ok;
    logic                 w_hit_ok;
    logic                 w_waiting;
    logic                 w_expired;

    // Restart the timer on every state change, count only while waiting.
    ctrl_wait_timer #(
        .MAX_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (w_next != r_state),
        .en_i     (w_waiting),
        .expired_o(w_expired)
    );

    // A hit is usable only if it points at a real entry.
    always_comb begin
        w_idx_ok  = 32'(lookup_idx_i) < NUM_ENTRIES;
        w_hit_ok  = lookup_hit_i && w_idx_ok;
        w_waiting = (r_state == DEL_ST_CHECK_EXISTS) ||
                    (r_state == ST_DEL_DELETE);
    end

    // Next-state decode; an ack in the expiry cycle takes priority.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            DEL_ST_START: begin
                if (start_i) w_next = DEL_ST_CHECK_EXISTS;
            end
            DEL_ST_CHECK_EXISTS: begin
                if (lookup_ack_i)
                    w_next = w_hit_ok ? ST_DEL_DELETE : ST_DEL_ERROR;
                else if (w_expired)
                    w_next = ST_DEL_ERROR;
            end
            ST_DEL_DELETE: begin
                if (clr_ack_i)      w_next = ST_DEL_DONE;
                else if (w_expired) w_next = ST_DEL_ERROR;
            end
            ST_DEL_DONE:  w_next = DEL_ST_START;
            ST_DEL_ERROR: w_next = DEL_ST_START;
            default:      w_next = DEL_ST_START;
        endcase
    end

    // State register plus key/index latches feeding the Moore outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DEL_ST_START;
            r_key   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == DEL_ST_START && start_i)
                r_key <= key_i;
            if (r_state == DEL_ST_CHECK_EXISTS && lookup_ack_i && w_hit_ok)
                r_idx <= lookup_idx_i;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        lookup_req_o = 1'b0;
        clr_req_o    = 1'b0;
        cmd_o        = '0;
        busy_o       = (r_state != DEL_ST_START);
        unique case (r_state)
            DEL_ST_CHECK_EXISTS: lookup_req_o = 1'b1;
            ST_DEL_DELETE:       clr_req_o    = 1'b1;
            ST_DEL_DONE:         cmd_o.done   = 1'b1;
            ST_DEL_ERROR:        cmd_o.error  = 1'b1;
            default:             ;
        endcase
    end

    assign lookup_key_o = r_key;
    assign clr_idx_o    = r_idx;
    assign state_o      = r_state;

endmodule

// File: tb/tb_ctrl_del_fsm.sv
// Scoreboard bench for ctrl_del_fsm.
// Expected results are queued at start and popped on each result pulse.
module tb_ctrl_del_fsm;
    import ctrl_types_pkg::*;

    localparam int NE = 12;
    localparam int KW = 64;
    localparam int IW = 4;
    localparam int TO = 4;

    localparam sub_cmd_t C_DONE = '{done: 1'b1, error: 1'b0};
    localparam sub_cmd_t C_ERR  = '{done: 1'b0, error: 1'b1};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [KW-1:0] key_i = '0;
    logic          lookup_req_o;
    logic [KW-1:0] lookup_key_o;
    logic          lookup_ack_i = 1'b0;
    logic          lookup_hit_i = 1'b0;
    logic [IW-1:0] lookup_idx_i = '0;
    logic          clr_req_o;
    logic [IW-1:0] clr_idx_o;
    logic          clr_ack_i = 1'b0;
    sub_cmd_t      cmd_o;
    logic          busy_o;
    del_substate_e state_o;

    int       n_chk  = 0;
    int       n_fail = 0;
    int       n_clr  = 0;
    sub_cmd_t q_exp[$];

    ctrl_del_fsm #(
        .NUM_ENTRIES   (NE),
        .KEY_WIDTH     (KW),
        .IDX_WIDTH     (IW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .key_i       (key_i),
        .lookup_req_o(lookup_req_o),
        .lookup_key_o(lookup_key_o),
        .lookup_ack_i(lookup_ack_i),
        .lookup_hit_i(lookup_hit_i),
        .lookup_idx_i(lookup_idx_i),
        .clr_req_o   (clr_req_o),
        .clr_idx_o   (clr_idx_o),
        .clr_ack_i   (clr_ack_i),
        .cmd_o       (cmd_o),
        .busy_o      (busy_o),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Launch one operation; returns at the negedge of cycle 1.
    task automatic do_start(input logic [KW-1:0] k);
        cyc();
        start_i = 1'b1;
        key_i   = k;
        cyc();
        start_i = 1'b0;
    endtask

    // Result monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (clr_req_o) n_clr++;
            if (cmd_o.done || cmd_o.error) begin
                chk("excl", 64'(cmd_o.done & cmd_o.error), 64'd0);
                if (q_exp.size() == 0)
                    chk("unexp_pulse", 64'(cmd_o), 64'd0);
                else
                    chk("result", 64'(cmd_o), 64'(q_exp.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int clr0;

        // Reset values
        #2;
        chk("rst_state", 64'(state_o), 64'(DEL_ST_START));
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_lreq", 64'(lookup_req_o), 0);
        chk("rst_key", lookup_key_o, 0);
        cyc();
        cyc();
        rst = 1'b0;

        // Hit path, zero-wait acks
        do_start(64'hDEAD_BEEF);
        q_exp.push_back(C_DONE);
        chk("hit_lreq_c1", 64'(lookup_req_o), 1);
        chk("hit_key_c1", lookup_key_o, 64'hDEAD_BEEF);
        chk("hit_busy_c1", 64'(busy_o), 1);
        lookup_ack_i = 1'b1;
        lookup_hit_i = 1'b1;
        lookup_idx_i = 4'd5;
        cyc();
        lookup_ack_i = 1'b0;
        lookup_hit_i = 1'b0;
        chk("hit_lreq_c2", 64'(lookup_req_o), 0);
        chk("hit_creq_c2", 64'(clr_req_o), 1);
        chk("hit_idx_c2", 64'(clr_idx_o), 5);
        clr_ack_i = 1'b1;
        cyc();
        clr_ack_i = 1'b0;
        chk("hit_done_c3", 64'(cmd_o), 64'(C_DONE));
        chk("hit_creq_c3", 64'(clr_req_o), 0);
        cyc();
        chk("hit_busy_c4", 64'(busy_o), 0);

        // Miss after two wait cycles
        clr0 = n_clr;
        do_start(64'h1234);
        q_exp.push_back(C_ERR);
        cyc();
        cyc();
        lookup_ack_i = 1'b1;
        lookup_hit_i = 1'b0;
        lookup_idx_i = 4'd2;
        cyc();
        lookup_ack_i = 1'b0;
        chk("miss_state", 64'(state_o), 64'(ST_DEL_ERROR));
        chk("miss_err", 64'(cmd_o), 64'(C_ERR));
        cyc();
        chk("miss_idle", 64'(state_o), 64'(DEL_ST_START));
        chk("miss_noclr", 64'(n_clr - clr0), 0);

        // Lookup timeout, then a late ack
        do_start(64'h5555);
        q_exp.push_back(C_ERR);
        n = 0;
        while (lookup_req_o && n < 20) begin
            n++;
            cyc();
        end
        chk("to_req_cycles", 64'(n), 64'(TO + 1));
        chk("to_state", 64'(state_o), 64'(ST_DEL_ERROR));
        cyc();
        lookup_ack_i = 1'b1;
        lookup_hit_i = 1'b1;
        lookup_idx_i = 4'd1;
        cyc();
        lookup_ack_i = 1'b0;
        lookup_hit_i = 1'b0;
        chk("late_ack_state", 64'(state_o), 64'(DEL_ST_START));
        chk("late_ack_creq", 64'(clr_req_o), 0);

        // Out-of-range index
        clr0 = n_clr;
        do_start(64'h7777);
        q_exp.push_back(C_ERR);
        lookup_ack_i = 1'b1;
        lookup_hit_i = 1'b1;
        lookup_idx_i = 4'd13;
        cyc();
        lookup_ack_i = 1'b0;
        lookup_hit_i = 1'b0;
        chk("oor_state", 64'(state_o), 64'(ST_DEL_ERROR));
        cyc();
        chk("oor_noclr", 64'(n_clr - clr0), 0);

        // Clear back-pressure with a start while busy
        do_start(64'hAAAA_0001);
        q_exp.push_back(C_DONE);
        lookup_ack_i = 1'b1;
        lookup_hit_i = 1'b1;
        lookup_idx_i = 4'd9;
        cyc();
        lookup_ack_i = 1'b0;
        lookup_hit_i = 1'b0;
        lookup_idx_i = 4'd0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_creq", 64'(clr_req_o), 1);
            chk("bp_idx", 64'(clr_idx_o), 9);
            chk("bp_key", lookup_key_o, 64'hAAAA_0001);
            start_i = (i == 1);
            key_i   = 64'hBBBB_0002;
            cyc();
        end
        start_i   = 1'b0;
        chk("bp_idx_ack", 64'(clr_idx_o), 9);
        clr_ack_i = 1'b1;
        cyc();
        clr_ack_i = 1'b0;
        chk("bp_done", 64'(cmd_o), 64'(C_DONE));
        start_i = 1'b1;
        key_i   = 64'hCCCC_0003;
        cyc();
        start_i = 1'b0;
        chk("res_start_ign", 64'(state_o), 64'(DEL_ST_START));
        chk("bp_key_kept", lookup_key_o, 64'hAAAA_0001);

        // Reset in the delete state
        do_start(64'h9999);
        lookup_ack_i = 1'b1;
        lookup_hit_i = 1'b1;
        lookup_idx_i = 4'd3;
        cyc();
        lookup_ack_i = 1'b0;
        lookup_hit_i = 1'b0;
        chk("mid_state", 64'(state_o), 64'(ST_DEL_DELETE));
        #2 rst = 1'b1;
        #1;
        chk("ar_state", 64'(state_o), 64'(DEL_ST_START));
        chk("ar_creq", 64'(clr_req_o), 0);
        chk("ar_idx", 64'(clr_idx_o), 0);
        chk("ar_key", lookup_key_o, 0);
        chk("ar_busy", 64'(busy_o), 0);
        chk("ar_cmd", 64'(cmd_o), 0);
        cyc();
        cyc();
        rst = 1'b0;

        // Fresh operation after reset
        do_start(64'h4242);
        q_exp.push_back(C_DONE);
        lookup_ack_i = 1'b1;
        lookup_hit_i = 1'b1;
        lookup_idx_i = 4'd11;
        cyc();
        lookup_ack_i = 1'b0;
        lookup_hit_i = 1'b0;
        chk("post_idx", 64'(clr_idx_o), 11);
        clr_ack_i = 1'b1;
        cyc();
        clr_ack_i = 1'b0;
        chk("post_done", 64'(cmd_o), 64'(C_DONE));
        cyc();
        cyc();
        chk("sb_empty", 64'(q_exp.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
